// File: rtl/cla_seq_pkg.sv
// cla_seq_pkg: shared FSM state type, default slice width and index-width helper.
package cla_seq_pkg;
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   localparam int SLICE_DEF = 4;
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction
endpackage

// File: rtl/cla_slice.sv
// cla_slice: combinational carry-look-ahead adder slice, every carry a flat sum of products.
module cla_slice
   import cla_seq_pkg::*;
#(
   parameter int W = SLICE_DEF
) (
   input  logic [W-1:0] x,
   input  logic [W-1:0] y,
   input  logic         ci,
   output logic [W-1:0] s,
   output logic         co
);
   logic [W-1:0] w_p, w_g;
   logic [W:0]   w_c;
   logic         w_t;
   assign w_p = x ^ y;
   assign w_g = x & y;
   always_comb begin
      w_c = '0;
      w_t = 1'b0;
      w_c[0] = ci;
      for (int i = 0; i < W; i++) begin
         w_t = ci;
         for (int k = 0; k <= i; k++) w_t = w_t & w_p[k];
         w_c[i+1] = w_t;
         for (int j = 0; j <= i; j++) begin
            w_t = w_g[j];
            for (int k = j + 1; k <= i; k++) w_t = w_t & w_p[k];
            w_c[i+1] = w_c[i+1] | w_t;
         end
      end
   end
   assign s  = w_p ^ w_c[W-1:0];
   assign co = w_c[W];
endmodule

// File: rtl/cla_seq_adder.sv
// cla_seq_adder: wide adder that walks one CLA slice across the operands, one slice per cycle.
module cla_seq_adder
   import cla_seq_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int SLICE = SLICE_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start_valid,
   output logic             start_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             done_valid,
   input  logic             done_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);
   localparam int NSLICE = WIDTH / SLICE;
   localparam int IW = idx_w(NSLICE);
   state_t           r_state, w_nxt;
   logic [IW-1:0]    r_idx;
   logic             r_carry, r_cout;
   logic [WIDTH-1:0] r_a, r_b, r_sum;
   logic [SLICE-1:0] w_s;
   logic             w_co, w_last;
   cla_slice #(.W(SLICE)) u_slice (
      .x  (r_a[r_idx*SLICE +: SLICE]),
      .y  (r_b[r_idx*SLICE +: SLICE]),
      .ci (r_carry),
      .s  (w_s),
      .co (w_co)
   );
   assign w_last = r_idx == IW'(NSLICE - 1);
   always_comb begin
      w_nxt = (r_state == IDLE) ? (start_valid ? RUN : IDLE)
            : (r_state == RUN)  ? (w_last ? DONE : RUN)
            : (done_ready ? IDLE : DONE);
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
         r_idx   <= '0;
         r_carry <= 1'b0;
         r_a     <= '0;
         r_b     <= '0;
         r_sum   <= '0;
         r_cout  <= 1'b0;
      end else begin
         r_state <= w_nxt;
         if (r_state == IDLE && start_valid) begin
            r_a     <= a;
            r_b     <= b;
            r_carry <= cin;
            r_idx   <= '0;
         end else if (r_state == RUN) begin
            r_sum[r_idx*SLICE +: SLICE] <= w_s;
            r_carry <= w_co;
            r_idx   <= w_last ? '0 : r_idx + 1'b1;
            if (w_last) r_cout <= w_co;
         end
      end
   end
   assign start_ready = r_state == IDLE;
   assign done_valid  = r_state == DONE;
   assign sum         = r_sum;
   assign cout        = r_cout;
endmodule
